// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader: the project-wide memory
// geometry defaults, the loader state encoding and the error codes
// reported on err_code.
package program_loader_pkg;

   // Project-wide memory geometry (same names and meaning as the core's pkg.v).
   localparam int ADDR_WIDTH       = 8;
   localparam int REG_WIDTH        = 8;
   localparam int INSTRUCTION_BASE = 16;
   localparam int MEM_DEPTH        = 256;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_VERIFY = 3'd3,
      ST_TAIL   = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_LEN    = 2'd1;
   localparam logic [1:0] ERR_VERIFY = 2'd2;

   // States in which a load is in progress.
   function automatic logic is_busy(input state_t s);
      return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERR);
   endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// byte_checksum
// Running modulo-2^DATA_WIDTH sum of bytes.
// Ports:
//   clk     clock
//   reset   synchronous active-high reset, clears the sum
//   clr     synchronous clear (start of a new load)
//   add_en  add din to the sum on this edge
//   din     byte to add
//   sum     current sum (registered)
module byte_checksum #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  add_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] sum
);

   logic [DATA_WIDTH-1:0] sum_reg;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         sum_reg <= '0;
      end else if (add_en) begin
         sum_reg <= sum_reg + din;
      end
   end

   assign sum = sum_reg;

endmodule

// File: rtl/program_loader.sv
// program_loader
// Fills the instruction region of memory from a byte stream while the CPU
// core is held in reset, then reads the region back and compares a read
// checksum against the write checksum.
// Ports:
//   clk       clock (phi2)
//   reset     synchronous active-high reset
//   start     load request, honoured only in IDLE/DONE/ERR
//   length    byte count, captured with start
//   s_valid   stream byte valid
//   s_data    stream byte
//   s_ready   loader accepts the stream byte this cycle
//   mem_we    memory write enable
//   mem_addr  memory address
//   mem_din   memory write data
//   mem_dout  memory read data, valid one cycle after mem_addr
//   cpu_hold  core held in reset, memory owned by the loader
//   busy      load in progress
//   done      one-cycle pulse on successful load
//   error     level, high in ERR
//   err_code  0 none, 1 length too large, 2 verify mismatch
//   checksum  sum of loaded bytes
// All outputs come straight from registers.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = program_loader_pkg::REG_WIDTH,
   parameter int BASE       = program_loader_pkg::INSTRUCTION_BASE,
   parameter int DEPTH      = program_loader_pkg::MEM_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   // One extra bit so a capacity equal to 2^ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0]   CAP      = (ADDR_WIDTH+1)'(DEPTH - BASE);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   count_reg, count_next;
   logic [ADDR_WIDTH-1:0]   len_reg, len_next;
   logic                    s_ready_reg, s_ready_next;
   logic                    mem_we_reg, mem_we_next;
   logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
   logic [DATA_WIDTH-1:0]   mem_din_reg, mem_din_next;
   logic                    cpu_hold_reg, cpu_hold_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;
   logic                    error_reg, error_next;
   logic [1:0]              err_code_reg, err_code_next;
   // High in the cycle after a read was issued, i.e. when mem_dout holds read data.
   logic                    rd_pend_reg, rd_pend_next;

   logic                    wr_clr, wr_add, rd_clr, rd_add;
   logic [DATA_WIDTH-1:0]   wr_sum, rd_sum;
   logic                    wr_accept;
   logic                    too_long;

   assign wr_accept = (state_reg == ST_WRITE) && s_valid && s_ready_reg;
   assign too_long  = {1'b0, length} > CAP;

   byte_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_wr_sum (
      .clk    (clk),
      .reset  (reset),
      .clr    (wr_clr),
      .add_en (wr_add),
      .din    (s_data),
      .sum    (wr_sum)
   );

   byte_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
      .clk    (clk),
      .reset  (reset),
      .clr    (rd_clr),
      .add_en (rd_add),
      .din    (mem_dout),
      .sum    (rd_sum)
   );

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      len_next      = len_reg;
      s_ready_next  = 1'b0;
      mem_we_next   = 1'b0;
      mem_addr_next = mem_addr_reg;
      mem_din_next  = mem_din_reg;
      cpu_hold_next = cpu_hold_reg;
      done_next     = 1'b0;
      error_next    = error_reg;
      err_code_next = err_code_reg;
      rd_pend_next  = 1'b0;
      wr_clr        = 1'b0;
      wr_add        = 1'b0;
      rd_clr        = 1'b0;
      rd_add        = 1'b0;

      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               cpu_hold_next = 1'b1;
               error_next    = 1'b0;
               err_code_next = ERR_NONE;
               if (too_long) begin
                  // Rejected before any write; the previous checksum stays visible.
                  state_next    = ST_ERR;
                  error_next    = 1'b1;
                  err_code_next = ERR_LEN;
               end else begin
                  len_next   = length;
                  count_next = '0;
                  wr_clr     = 1'b1;
                  rd_clr     = 1'b1;
                  if (length == '0) begin
                     state_next = ST_CHECK;
                  end else begin
                     state_next   = ST_WRITE;
                     s_ready_next = 1'b1;
                  end
               end
            end
         end

         ST_WRITE: begin
            s_ready_next = 1'b1;
            if (wr_accept) begin
               mem_we_next   = 1'b1;
               mem_addr_next = BASE_A + count_reg;
               mem_din_next  = s_data;
               wr_add        = 1'b1;
               count_next    = count_reg + ADDR_ONE;
               if (count_reg + ADDR_ONE == len_reg) begin
                  s_ready_next = 1'b0;
                  state_next   = ST_FLUSH;
               end
            end
         end

         ST_FLUSH: begin
            // The last write is on the port this cycle; queue the first read
            // and count it as already issued.
            mem_addr_next = BASE_A;
            count_next    = ADDR_ONE;
            state_next    = ST_VERIFY;
         end

         ST_VERIFY: begin
            rd_pend_next = 1'b1;
            rd_add       = rd_pend_reg;
            if (count_reg == len_reg) begin
               state_next = ST_TAIL;
            end else begin
               mem_addr_next = BASE_A + count_reg;
               count_next    = count_reg + ADDR_ONE;
            end
         end

         ST_TAIL: begin
            rd_add     = rd_pend_reg;
            state_next = ST_CHECK;
         end

         ST_CHECK: begin
            if (wr_sum == rd_sum) begin
               state_next    = ST_DONE;
               done_next     = 1'b1;
               cpu_hold_next = 1'b0;
            end else begin
               state_next    = ST_ERR;
               error_next    = 1'b1;
               err_code_next = ERR_VERIFY;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      busy_next = is_busy(state_next);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         len_reg      <= '0;
         s_ready_reg  <= 1'b0;
         mem_we_reg   <= 1'b0;
         mem_addr_reg <= '0;
         mem_din_reg  <= '0;
         cpu_hold_reg <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         err_code_reg <= ERR_NONE;
         rd_pend_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         len_reg      <= len_next;
         s_ready_reg  <= s_ready_next;
         mem_we_reg   <= mem_we_next;
         mem_addr_reg <= mem_addr_next;
         mem_din_reg  <= mem_din_next;
         cpu_hold_reg <= cpu_hold_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         err_code_reg <= err_code_next;
         rd_pend_reg  <= rd_pend_next;
      end
   end

   assign s_ready  = s_ready_reg;
   assign mem_we   = mem_we_reg;
   assign mem_addr = mem_addr_reg;
   assign mem_din  = mem_din_reg;
   assign cpu_hold = cpu_hold_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign error    = error_reg;
   assign err_code = err_code_reg;
   assign checksum = wr_sum;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Drives program_loader against a single-port memory model with registered
// read. Expected writes are queued as stream bytes are accepted and popped
// as mem_we pulses appear.
module tb_program_loader;

   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int BASE  = 16;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] length;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    err_code;
   logic [DW-1:0] checksum;

   always #5 clk = ~clk;

   program_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BASE       (BASE),
      .DEPTH      (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .length   (length),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .err_code (err_code),
      .checksum (checksum)
   );

   // Memory model: write-first single port, registered read, optional
   // corruption of the read of address 17.
   logic [DW-1:0] mem_m [0:DEPTH-1];
   logic          flip_en;

   always @(posedge clk) begin
      if (mem_we) mem_m[mem_addr[4:0]] <= mem_din;
      mem_dout <= mem_m[mem_addr[4:0]] ^ ((flip_en && !mem_we && mem_addr == AW'(17)) ? 8'h01 : 8'h00);
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   logic [DW-1:0] stim [0:15];
   logic [15:0]   exp_q [$];
   int done_cyc, err_cyc, we_cnt, last_rd_cyc;

   // One load: start sampled at the edge ending cycle 0; cycle n is observed
   // at the negedge after the n-th following posedge.
   task automatic run_load(input int len, input int gap);
      int idx;
      int stop_at;
      logic [15:0] expv;
      idx = 0; done_cyc = -1; err_cyc = -1; we_cnt = 0; last_rd_cyc = -1; stop_at = -1;
      @(negedge clk);
      start   = 1'b1;
      length  = AW'(len);
      s_valid = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
               check_val("sb_extra_write", 32'({mem_addr, mem_din}), 32'hFFFF_FFFF);
            end else begin
               expv = exp_q.pop_front();
               check_val("sb_write", 32'({mem_addr, mem_din}), 32'(expv));
            end
         end
         if (done && done_cyc < 0) done_cyc = n;
         if (error && err_cyc < 0) err_cyc = n;
         if (last_rd_cyc < 0 && len > 0 && busy && !mem_we && we_cnt == len
             && mem_addr == AW'(BASE + len - 1)) last_rd_cyc = n;
         start   = 1'b0;
         s_valid = (idx < len) && (gap == 0 || (n % 2) == 0);
         s_data  = (idx < 16) ? stim[idx] : 8'h00;
         if (s_valid && s_ready) begin
            exp_q.push_back({AW'(BASE + idx), s_data});
            idx++;
         end
         if (stop_at < 0 && (done_cyc > 0 || err_cyc > 0)) stop_at = n + 2;
         if (n == stop_at) break;
      end
      s_valid = 1'b0;
      if (done_cyc < 0 && err_cyc < 0) check_val("timeout", 32'd1, 32'd0);
      check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; length = '0; s_valid = 1'b0; s_data = '0; flip_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check_val("rst_flags", 32'({s_ready, busy, done, error, mem_we}), 32'd0);
      check_val("rst_vals", 32'({err_code, checksum, mem_addr, mem_din}), 32'd0);
      reset = 1'b0;

      // Continuous load of four bytes.
      stim[0] = 8'hA9; stim[1] = 8'h05; stim[2] = 8'h85; stim[3] = 8'h10;
      run_load(4, 0);
      check_val("t1_done_cyc", 32'(done_cyc), 32'd12);
      check_val("t1_checksum", 32'(checksum), 32'h43);
      check_val("t1_cpu_hold", 32'(cpu_hold), 32'd0);
      check_val("t1_error", 32'(error), 32'd0);
      check_val("t1_we_cnt", 32'(we_cnt), 32'd4);
      for (int i = 0; i < 4; i++) check_val("t1_mem", 32'(mem_m[BASE + i]), 32'(stim[i]));

      // Same load with backpressure on alternate cycles.
      for (int i = 16; i < 20; i++) mem_m[i] = 8'h00;
      run_load(4, 1);
      check_val("t2_we_cnt", 32'(we_cnt), 32'd4);
      check_val("t2_done_after_tail", 32'(done_cyc - last_rd_cyc), 32'd3);
      check_val("t2_checksum", 32'(checksum), 32'h43);
      for (int i = 0; i < 4; i++) check_val("t2_mem", 32'(mem_m[BASE + i]), 32'(stim[i]));

      // Length beyond capacity.
      run_load(17, 0);
      check_val("t3_err_cyc", 32'(err_cyc), 32'd1);
      check_val("t3_err_code", 32'(err_code), 32'd1);
      check_val("t3_we_cnt", 32'(we_cnt), 32'd0);
      check_val("t3_cpu_hold", 32'(cpu_hold), 32'd1);

      // Corrupted read-back of address 17.
      flip_en = 1'b1;
      run_load(4, 0);
      flip_en = 1'b0;
      check_val("t4_err_code", 32'(err_code), 32'd2);
      check_val("t4_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
      check_val("t4_cpu_hold", 32'(cpu_hold), 32'd1);
      check_val("t4_error", 32'(error), 32'd1);

      // Reset after two accepted bytes, then a fresh three-byte load.
      stim[0] = 8'h3C; stim[1] = 8'hC3; stim[2] = 8'h7E;
      @(negedge clk);
      start = 1'b1; length = AW'(4);
      @(negedge clk);
      start = 1'b0; s_valid = 1'b1; s_data = stim[0];
      @(negedge clk);
      s_data = stim[1];
      @(negedge clk);
      s_valid = 1'b0; reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("t5_rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check_val("t5_rst_flags", 32'({s_ready, busy, done, error, mem_we}), 32'd0);
      check_val("t5_rst_vals", 32'({err_code, checksum, mem_addr, mem_din}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_load(3, 0);
      check_val("t5_done_cyc", 32'(done_cyc), 32'd10);
      check_val("t5_checksum", 32'(checksum), 32'h7D);
      for (int i = 0; i < 3; i++) check_val("t5_mem", 32'(mem_m[BASE + i]), 32'(stim[i]));

      // Zero-length load.
      run_load(0, 0);
      check_val("t6_done_cyc", 32'(done_cyc), 32'd2);
      check_val("t6_checksum", 32'(checksum), 32'h00);
      check_val("t6_we_cnt", 32'(we_cnt), 32'd0);
      check_val("t6_addr_held", 32'(mem_addr), 32'(BASE + 2));
      check_val("t6_cpu_hold", 32'(cpu_hold), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
